// File: rtl/reg_cmd_master.sv
// Register command master: queues {wr, addr, wdata} commands in a FIFO and plays them onto a sel/ready register port, one response per command.
// Optional ready timeout is enabled by defining REG_CMD_TIMEOUT_EN.
module reg_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready,
  output logic                  busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("reg_cmd_master: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          empty, full, push, pop;
  logic [EW-1:0] head;

  logic [1:0]            state_q, state_d;
  logic                  sel_q, sel_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_wr_q, rsp_wr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef REG_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // The extra MSB on each pointer separates full from empty when the index bits match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= {cmd_wr, cmd_addr, cmd_wdata};
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
`ifdef REG_CMD_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_ISSUE: begin
        if (ready) begin
          rsp_rdata_d = wr_q ? '0 : rdata;
          rsp_wr_d    = wr_q;
          rsp_valid_d = 1'b1;
          sel_d       = 1'b0;
          wr_d        = 1'b0;
          state_d     = S_RESP;
`ifdef REG_CMD_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_rdata_d = '0;
          rsp_wr_d    = wr_q;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          sel_d       = 1'b0;
          wr_d        = 1'b0;
          state_d     = S_RESP;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Popping loads the head straight onto the register port, so RESP can chain into ISSUE.
    if (pop) begin
      sel_d   = 1'b1;
      wr_d    = head[EW-1];
      addr_d  = head[EW-2 -: ADDR_WIDTH];
      wdata_d = head[DATA_WIDTH-1:0];
      state_d = S_ISSUE;
`ifdef REG_CMD_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end
    wptr_d = wptr_q + {{PW{1'b0}}, push};
    rptr_d = rptr_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef REG_CMD_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef REG_CMD_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef REG_CMD_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: table of single commands, then backpressure, stray ready, reset and timeout sequences.
module tb_reg_cmd_master;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [AW-1:0] cmd_addr, addr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, rdata;
  logic          sel, wr, ready, busy;

  reg_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_wr(rsp_wr), .rsp_err(rsp_err), .sel(sel), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int lat; logic [DW-1:0] exp_rdata; } vec_t;
  typedef struct { bit wr; logic [DW-1:0] rdata; bit err; } rsp_t;
  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;

  int checks = 0;
  int errors = 0;
  rsp_t exp_q[$];
  iss_t issue_q[$];
  logic [DW-1:0] regmem [256];
  int  lat_cfg = 1;
  bit  hold_ready = 0;
  bit  resp_en = 1;
  bit  check_b2b = 0;
  bit  pending_b2b = 0;
  int  rsp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Register slave: answers sel after lat_cfg cycles, checks issue order and signal stability.
  initial begin : responder
    bit in_txn = 0;
    int cnt = 0;
    iss_t cur, e;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;
    ready = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) continue;
      if (rst) begin
        ready = 1'b0; in_txn = 0; last_addr = '0; last_wdata = '0;
        continue;
      end
      if (ready) begin
        ready = 1'b0;
      end else if (sel) begin
        if (!in_txn) begin
          in_txn = 1; cnt = 0;
          cur.wr = wr; cur.addr = addr; cur.wdata = wdata;
          last_addr = addr; last_wdata = wdata;
          if (issue_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
          else begin
            e = issue_q.pop_front();
            check("issue_cmd", {7'd0, wr, addr, wdata}, {7'd0, e.wr, e.addr, e.wdata});
          end
        end else begin
          check("issue_stable", {7'd0, wr, addr, wdata}, {7'd0, cur.wr, cur.addr, cur.wdata});
        end
        rdata = DW'($urandom);
        if (!hold_ready) begin
          if (cnt >= lat_cfg) begin
            ready = 1'b1;
            rdata = regmem[cur.addr];
            if (cur.wr) regmem[cur.addr] = cur.wdata;
            in_txn = 0;
          end else cnt++;
        end
      end else begin
        in_txn = 0;
        rdata = DW'($urandom);
        check("idle_port", {7'd0, wr, addr, wdata}, {7'd0, 1'b0, last_addr, last_wdata});
      end
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (pending_b2b) begin
        pending_b2b = 0;
        check("b2b_issue", {31'd0, sel}, 32'd1);
      end
      if (!rst && rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          if (check_b2b && exp_q.size() > 1) pending_b2b = 1;
          e = exp_q.pop_front();
          check("rsp", {14'd0, rsp_wr, rsp_err, rsp_rdata}, {14'd0, e.wr, e.err, e.rdata});
        end
      end
    end
  end

  task automatic push_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input bit exp_err);
    rsp_t r;
    iss_t i;
    bit ok = 0;
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
    else begin
      r.wr = w; r.rdata = w ? '0 : exp_rd; r.err = exp_err;
      i.wr = w; i.addr = a; i.wdata = d;
      exp_q.push_back(r);
      issue_q.push_back(i);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    issue_q.delete();
  endtask

  vec_t vecs[11];
  initial begin : main
    int n;
    int saved;
    bit ok;
    vecs[0]  = '{1'b1, 8'h05, 16'hBEEF, 1, 16'h0000};
    vecs[1]  = '{1'b0, 8'h05, 16'h0000, 1, 16'hBEEF};
    vecs[2]  = '{1'b1, 8'h10, 16'h1234, 0, 16'h0000};
    vecs[3]  = '{1'b1, 8'h11, 16'hABCD, 3, 16'h0000};
    vecs[4]  = '{1'b0, 8'h10, 16'h5555, 0, 16'h1234};
    vecs[5]  = '{1'b0, 8'h11, 16'h0000, 2, 16'hABCD};
    vecs[6]  = '{1'b1, 8'h05, 16'h0000, 1, 16'h0000};
    vecs[7]  = '{1'b0, 8'h05, 16'hFFFF, 1, 16'h0000};
    vecs[8]  = '{1'b1, 8'hFF, 16'hFFFF, 0, 16'h0000};
    vecs[9]  = '{1'b0, 8'hFF, 16'h0000, 0, 16'hFFFF};
    vecs[10] = '{1'b0, 8'h20, 16'h0000, 4, 16'h0000};
    for (int i = 0; i < 256; i++) regmem[i] = '0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_port", {6'd0, sel, wr, addr, wdata}, 32'd0);
    check("reset_rsp", {13'd0, rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 32'd0);
    check("reset_ctrl", {30'd0, busy, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      lat_cfg = vecs[i].lat;
      push_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
      @(negedge clk);
      check("issue_latency", {31'd0, sel}, 32'd0);
      wait_idle();
    end

    // Stray ready while idle must not produce anything.
    resp_en = 0; ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_ready", {30'd0, rsp_valid, busy}, 32'd0);
    end
    ready = 1'b0; resp_en = 1;
    @(posedge clk); #1;

    // Backpressure: one command parked in RESP, four filling the FIFO.
    saved = rsp_cnt;
    lat_cfg = 0; rsp_ready = 1'b0;
    push_cmd(1'b1, 8'h40, 16'h1111, 16'h0, 1'b0);
    push_cmd(1'b1, 8'h41, 16'h2222, 16'h0, 1'b0);
    push_cmd(1'b0, 8'h40, 16'h0000, 16'h1111, 1'b0);
    push_cmd(1'b0, 8'h41, 16'h0000, 16'h2222, 1'b0);
    push_cmd(1'b1, 8'h42, 16'h3333, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    check("full_ready_low", {29'd0, cmd_ready, busy, rsp_valid}, 32'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h42; cmd_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      check("full_hold", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk); #1;
    check_b2b = 1; rsp_ready = 1'b1;
    @(negedge clk);
    check("full_with_pop", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    push_cmd(1'b0, 8'h42, 16'h0000, 16'h3333, 1'b0);
    wait_idle();
    check_b2b = 0;
    check("bp_rsp_count", rsp_cnt - saved, 32'd6);

    // Reset in the middle of ISSUE with two commands still queued.
    lat_cfg = 1; hold_ready = 1;
    push_cmd(1'b0, 8'h60, 16'h0, 16'h0, 1'b0);
    push_cmd(1'b0, 8'h61, 16'h0, 16'h0, 1'b0);
    push_cmd(1'b0, 8'h62, 16'h0, 16'h0, 1'b0);
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sel) begin ok = 1; break; end
    end
    check("reset_wait_sel", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    saved = rsp_cnt;
    pulse_reset();
    hold_ready = 0;
    @(negedge clk);
    check("midreset_state", {28'd0, sel, rsp_valid, busy, cmd_ready}, 32'd1);
    check("midreset_port", {16'd0, addr, wdata[7:0]}, 32'd0);
    repeat (10) @(negedge clk);
    check("midreset_no_rsp", rsp_cnt - saved, 32'd0);
    @(posedge clk); #1;
    push_cmd(1'b0, 8'h10, 16'h0, 16'h1234, 1'b0);
    wait_idle();

    // Ready never returns.
    hold_ready = 1;
    saved = rsp_cnt;
`ifdef REG_CMD_TIMEOUT_EN
    push_cmd(1'b0, 8'h11, 16'h0, 16'h0000, 1'b1);
`else
    push_cmd(1'b0, 8'h11, 16'h0, 16'h0000, 1'b0);
`endif
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (sel) begin ok = 1; break; end
    end
    check("tmo_wait_sel", {31'd0, ok}, 32'd1);
    n = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!sel) break;
      n++;
    end
`ifdef REG_CMD_TIMEOUT_EN
    check("tmo_sel_cycles", n, TMO);
    wait_idle();
    check("tmo_rsp_count", rsp_cnt - saved, 32'd1);
    hold_ready = 0;
`else
    check("no_tmo_sel_held", {31'd0, sel}, 32'd1);
    check("no_tmo_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("no_tmo_rsp_count", rsp_cnt - saved, 32'd0);
    @(posedge clk); #1;
    pulse_reset();
    hold_ready = 0;
    @(negedge clk);
    check("no_tmo_cleared", {30'd0, sel, busy}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
